// File: rtl/tlb_refill_ctrl.sv
// rtl/tlb_refill_ctrl.sv - hardware TLB refill walker for a single-level page table
// Reads the PTE for a user-mode miss and either writes the TLB or raises a page fault.
module tlb_refill_ctrl #(
   parameter int VPN_WIDTH = 20,
   parameter int PPN_WIDTH = 20,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 tlb_miss_i,
   input  logic                 privilege_i,
   input  logic [VPN_WIDTH-1:0] miss_vpn_i,
   input  logic [31:0]          ptbr_i,
   output logic                 mem_req_o,
   output logic [31:0]          mem_addr_o,
   input  logic                 mem_ack_i,
   input  logic [31:0]          mem_data_i,
   output logic [VPN_WIDTH-1:0] w_virtual_page_o,
   output logic [PPN_WIDTH-1:0] w_phys_page_o,
   output logic                 write_enable_o,
   output logic                 busy_o,
   output logic                 fault_o,
   output logic [VPN_WIDTH-1:0] fault_vpn_o,
   input  logic                 fault_clear_i
);

   localparam int                CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WRITE,
      S_SETTLE,
      S_FAULT
   } state_t;

   state_t               state_q, state_d;
   logic [VPN_WIDTH-1:0] vpn_q, vpn_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [VPN_WIDTH-1:0] w_vpn_q, w_vpn_d;
   logic [PPN_WIDTH-1:0] w_ppn_q, w_ppn_d;
   logic [VPN_WIDTH-1:0] fault_vpn_q, fault_vpn_d;
   logic                 mem_req_q;
   logic                 we_q;
   logic                 busy_q;
   logic                 fault_q;
   logic                 unused_pte_bits;

   // Only the valid bit and the PPN field of the PTE carry meaning.
   assign unused_pte_bits = ^mem_data_i;

   always_comb begin
      state_d     = state_q;
      vpn_d       = vpn_q;
      cnt_d       = cnt_q;
      w_vpn_d     = w_vpn_q;
      w_ppn_d     = w_ppn_q;
      fault_vpn_d = fault_vpn_q;
      case (state_q)
         S_IDLE: begin
            if (tlb_miss_i && !privilege_i) begin
               vpn_d   = miss_vpn_i;
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // An ack in the final timeout cycle still completes the walk.
            if (mem_ack_i) begin
               if (mem_data_i[31]) begin
                  w_vpn_d = vpn_q;
                  w_ppn_d = mem_data_i[PPN_WIDTH-1:0];
                  state_d = S_WRITE;
               end else begin
                  fault_vpn_d = vpn_q;
                  state_d     = S_FAULT;
               end
            end else if (cnt_q == CNT_MAX) begin
               fault_vpn_d = vpn_q;
               state_d     = S_FAULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WRITE:  state_d = S_SETTLE;
         S_SETTLE: state_d = S_IDLE;
         S_FAULT: begin
            if (fault_clear_i) begin
               state_d = S_IDLE;
            end
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         vpn_q       <= '0;
         cnt_q       <= '0;
         w_vpn_q     <= '0;
         w_ppn_q     <= '0;
         fault_vpn_q <= '0;
         mem_req_q   <= 1'b0;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         vpn_q       <= vpn_d;
         cnt_q       <= cnt_d;
         w_vpn_q     <= w_vpn_d;
         w_ppn_q     <= w_ppn_d;
         fault_vpn_q <= fault_vpn_d;
         mem_req_q   <= (state_d == S_REQ);
         we_q        <= (state_d == S_WRITE);
         busy_q      <= (state_d == S_REQ) || (state_d == S_WRITE) || (state_d == S_SETTLE);
         fault_q     <= (state_d == S_FAULT);
      end
   end

   // The base register is not captured, so the address follows ptbr_i live.
   assign mem_addr_o       = mem_req_q ? (ptbr_i + 32'({vpn_q, 2'b00})) : 32'h0;
   assign mem_req_o        = mem_req_q;
   assign write_enable_o   = we_q;
   assign w_virtual_page_o = w_vpn_q;
   assign w_phys_page_o    = w_ppn_q;
   assign busy_o           = busy_q;
   assign fault_o          = fault_q;
   assign fault_vpn_o      = fault_vpn_q;

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// tb/tb_tlb_refill_ctrl.sv - self-checking bench for tlb_refill_ctrl
module tb_tlb_refill_ctrl;

   localparam int VW = 20;
   localparam int PW = 20;
   localparam int TO = 64;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          tlb_miss_i = 1'b0;
   logic          privilege_i = 1'b0;
   logic [VW-1:0] miss_vpn_i = '0;
   logic [31:0]   ptbr_i = '0;
   logic          mem_req_o;
   logic [31:0]   mem_addr_o;
   logic          mem_ack_i = 1'b0;
   logic [31:0]   mem_data_i = '0;
   logic [VW-1:0] w_virtual_page_o;
   logic [PW-1:0] w_phys_page_o;
   logic          write_enable_o;
   logic          busy_o;
   logic          fault_o;
   logic [VW-1:0] fault_vpn_o;
   logic          fault_clear_i = 1'b0;

   tlb_refill_ctrl #(.VPN_WIDTH(VW), .PPN_WIDTH(PW), .TIMEOUT(TO)) dut (
      .clock            (clock),
      .reset            (reset),
      .tlb_miss_i       (tlb_miss_i),
      .privilege_i      (privilege_i),
      .miss_vpn_i       (miss_vpn_i),
      .ptbr_i           (ptbr_i),
      .mem_req_o        (mem_req_o),
      .mem_addr_o       (mem_addr_o),
      .mem_ack_i        (mem_ack_i),
      .mem_data_i       (mem_data_i),
      .w_virtual_page_o (w_virtual_page_o),
      .w_phys_page_o    (w_phys_page_o),
      .write_enable_o   (write_enable_o),
      .busy_o           (busy_o),
      .fault_o          (fault_o),
      .fault_vpn_o      (fault_vpn_o),
      .fault_clear_i    (fault_clear_i)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   int pushes = 0;
   int writes_seen = 0;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [VW-1:0] vpn;
      logic [PW-1:0] ppn;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;

   // Every TLB write must match the oldest pair the bench queued when it acked a valid PTE.
   always @(negedge clock) begin
      if (reset && write_enable_o) begin
         writes_seen++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got vpn 0x%0h ppn 0x%0h, expected no write",
                     w_virtual_page_o, w_phys_page_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_vpn", 32'(w_virtual_page_o), 32'(mon_e.vpn));
            check("write_ppn", 32'(w_phys_page_o), 32'(mon_e.ppn));
         end
      end
   end

   typedef struct {
      logic [VW-1:0] vpn;
      logic [31:0]   ptbr;
      logic [31:0]   pte;
      int            ack_delay;
      logic [31:0]   exp_addr;
      logic [PW-1:0] exp_ppn;
      bit            exp_fault;
   } vec_t;

   vec_t vecs[8];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int start;
      tlb_miss_i  = 1'b1;
      privilege_i = 1'b0;
      miss_vpn_i  = v.vpn;
      ptbr_i      = v.ptbr;
      start       = cycle;
      step();
      tlb_miss_i = 1'b0;
      miss_vpn_i = '0;
      check({tag, ".req"},  32'(mem_req_o), 32'd1);
      check({tag, ".busy"}, 32'(busy_o), 32'd1);
      check({tag, ".addr"}, mem_addr_o, v.exp_addr);
      repeat (v.ack_delay) step();
      check({tag, ".req_held"}, 32'(mem_req_o), 32'd1);
      mem_ack_i  = 1'b1;
      mem_data_i = v.pte;
      if (!v.exp_fault) begin
         exp_q.push_back(wr_t'{vpn: v.vpn, ppn: v.exp_ppn});
         pushes++;
      end
      step();
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      if (!v.exp_fault) begin
         check({tag, ".we"},      32'(write_enable_o), 32'd1);
         check({tag, ".latency"}, 32'(cycle - start), 32'(2 + v.ack_delay));
         check({tag, ".wr_req"},  32'(mem_req_o), 32'd0);
         check({tag, ".wr_busy"}, 32'(busy_o), 32'd1);
         step();
         check({tag, ".settle_we"},   32'(write_enable_o), 32'd0);
         check({tag, ".settle_busy"}, 32'(busy_o), 32'd1);
         step();
         check({tag, ".idle_busy"}, 32'(busy_o), 32'd0);
      end else begin
         check({tag, ".fault"},      32'(fault_o), 32'd1);
         check({tag, ".fault_vpn"},  32'(fault_vpn_o), 32'(v.vpn));
         check({tag, ".fault_busy"}, 32'(busy_o), 32'd0);
         check({tag, ".fault_we"},   32'(write_enable_o), 32'd0);
         fault_clear_i = 1'b1;
         step();
         fault_clear_i = 1'b0;
         check({tag, ".cleared"},    32'(fault_o), 32'd0);
         check({tag, ".clr_req"},    32'(mem_req_o), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      int k;
      vecs[0] = '{20'd2,     32'h0000_1000, 32'h8000_0004, 3, 32'h0000_1008, 20'h4,     1'b0};
      vecs[1] = '{20'd45,    32'h0000_1000, 32'h0000_0006, 1, 32'h0000_10B4, 20'h0,     1'b1};
      vecs[2] = '{20'd5,     32'h0000_2000, 32'h8000_0007, 0, 32'h0000_2014, 20'h7,     1'b0};
      vecs[3] = '{20'd6,     32'h0000_2000, 32'h8000_0008, 0, 32'h0000_2018, 20'h8,     1'b0};
      vecs[4] = '{20'd7,     32'h0000_2000, 32'h8000_0009, 0, 32'h0000_201C, 20'h9,     1'b0};
      vecs[5] = '{20'd8,     32'h0000_2000, 32'h8000_000A, 0, 32'h0000_2020, 20'hA,     1'b0};
      vecs[6] = '{20'hFFFFF, 32'hFFFF_FFF0, 32'hFFF1_2345, 2, 32'h003F_FFEC, 20'h12345, 1'b0};
      vecs[7] = '{20'h80,    32'h0000_1000, 32'h7FFF_FFFF, 5, 32'h0000_1200, 20'h0,     1'b1};

      repeat (3) step();
      check("rst.req",       32'(mem_req_o), 32'd0);
      check("rst.addr",      mem_addr_o, 32'd0);
      check("rst.we",        32'(write_enable_o), 32'd0);
      check("rst.busy",      32'(busy_o), 32'd0);
      check("rst.fault",     32'(fault_o), 32'd0);
      check("rst.fault_vpn", 32'(fault_vpn_o), 32'd0);
      check("rst.w_vpn",     32'(w_virtual_page_o), 32'd0);
      check("rst.w_ppn",     32'(w_phys_page_o), 32'd0);
      reset = 1'b1;
      step();

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Privileged misses never start a walk.
      tlb_miss_i  = 1'b1;
      privilege_i = 1'b1;
      miss_vpn_i  = 20'h77;
      for (int i = 0; i < 10; i++) begin
         step();
         check("priv.req",  32'(mem_req_o), 32'd0);
         check("priv.busy", 32'(busy_o), 32'd0);
      end
      tlb_miss_i  = 1'b0;
      privilege_i = 1'b0;
      step();

      // A miss held through WRITE and SETTLE only starts a walk from the following IDLE cycle.
      tlb_miss_i = 1'b1;
      miss_vpn_i = 20'h11;
      ptbr_i     = 32'h0000_3000;
      step();
      tlb_miss_i = 1'b0;
      mem_ack_i  = 1'b1;
      mem_data_i = 32'h8000_0021;
      exp_q.push_back(wr_t'{vpn: 20'h11, ppn: 20'h21});
      pushes++;
      step();
      mem_ack_i  = 1'b0;
      tlb_miss_i = 1'b1;
      miss_vpn_i = 20'h12;
      step();
      check("settle.busy", 32'(busy_o), 32'd1);
      check("settle.req",  32'(mem_req_o), 32'd0);
      step();
      check("settle.idle_req", 32'(mem_req_o), 32'd0);
      step();
      tlb_miss_i = 1'b0;
      check("settle.rewalk_req",  32'(mem_req_o), 32'd1);
      check("settle.rewalk_addr", mem_addr_o, 32'h0000_3048);
      mem_ack_i  = 1'b1;
      mem_data_i = 32'h8000_0022;
      exp_q.push_back(wr_t'{vpn: 20'h12, ppn: 20'h22});
      pushes++;
      step();
      mem_ack_i = 1'b0;
      repeat (2) step();

      // Timeout: fault exactly TIMEOUT cycles after the request rises; late acks and misses ignored.
      tlb_miss_i = 1'b1;
      miss_vpn_i = 20'd3;
      ptbr_i     = 32'h0000_1000;
      step();
      tlb_miss_i = 1'b0;
      check("to.req", 32'(mem_req_o), 32'd1);
      k = 0;
      while (!fault_o && k < 200) begin
         step();
         k++;
      end
      check("to.cycles",    32'(k), 32'(TO));
      check("to.fault_vpn", 32'(fault_vpn_o), 32'd3);
      check("to.req_drop",  32'(mem_req_o), 32'd0);
      tlb_miss_i = 1'b1;
      miss_vpn_i = 20'd4;
      mem_ack_i  = 1'b1;
      mem_data_i = 32'h8000_0001;
      step();
      mem_ack_i  = 1'b0;
      tlb_miss_i = 1'b0;
      check("to.late_fault", 32'(fault_o), 32'd1);
      check("to.late_req",   32'(mem_req_o), 32'd0);
      check("to.late_vpn",   32'(fault_vpn_o), 32'd3);
      fault_clear_i = 1'b1;
      step();
      fault_clear_i = 1'b0;
      check("to.cleared", 32'(fault_o), 32'd0);

      // Reset two cycles into REQ aborts the walk without a TLB write.
      tlb_miss_i = 1'b1;
      miss_vpn_i = 20'd9;
      step();
      tlb_miss_i = 1'b0;
      step();
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check("abort.req",   32'(mem_req_o), 32'd0);
      check("abort.we",    32'(write_enable_o), 32'd0);
      check("abort.busy",  32'(busy_o), 32'd0);
      check("abort.addr",  mem_addr_o, 32'd0);
      check("abort.w_vpn", 32'(w_virtual_page_o), 32'd0);
      mem_ack_i  = 1'b1;
      mem_data_i = 32'h8000_0005;
      repeat (2) step();
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      reset      = 1'b1;
      repeat (3) step();
      check("abort.idle_req",   32'(mem_req_o), 32'd0);
      check("abort.idle_busy",  32'(busy_o), 32'd0);
      check("abort.idle_fault", 32'(fault_o), 32'd0);
      run_vec(vecs[0], "post_abort");

      repeat (3) step();
      check("sb.write_count", 32'(writes_seen), 32'(pushes));
      check("sb.queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tlb_refill_ctrl.md
Name: tlb_refill_ctrl

Overview:
- Hardware TLB miss handler that sits between the tlb block and the data memory port.
- On a user-mode TLB miss, it reads the page-table entry for the missing virtual page from a single-level page table in memory.
- A valid entry is written into the TLB through the TLB's write port; an invalid entry, or a memory timeout, raises a page fault.
- The pipeline stalls on busy_o while a refill is in progress.

Parameters:
- VPN_WIDTH, 20, virtual page number width (32 - OFFSET).
- PPN_WIDTH, 20, physical page number width written to the TLB.
- TIMEOUT, 64, maximum cycles to wait for mem_ack_i before faulting (must be >= 2).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- tlb_miss_i  in  1  miss flag from the TLB for the current lookup.
- privilege_i  in  1  1 = privileged access (bypasses translation, never triggers a refill).
- miss_vpn_i  in  VPN_WIDTH  virtual page of the current lookup.
- ptbr_i  in  32  page-table base byte address, word aligned.
- mem_req_o  out  1  memory read request, held until acknowledged.
- mem_addr_o  out  32  PTE byte address.
- mem_ack_i  in  1  memory read data valid, single-cycle pulse.
- mem_data_i  in  32  PTE: bit31 = valid, bits[PPN_WIDTH-1:0] = physical page number.
- w_virtual_page_o  out  VPN_WIDTH  to the TLB's w_virtual_page_i.
- w_phys_page_o  out  PPN_WIDTH  to the TLB's w_phys_page_i.
- write_enable_o  out  1  to the TLB's write_enable_i.
- busy_o  out  1  stall request to the pipeline.
- fault_o  out  1  page fault pending.
- fault_vpn_o  out  VPN_WIDTH  faulting virtual page.
- fault_clear_i  in  1  exception logic acknowledges the fault.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE. All outputs are 0, including the latched VPN, PPN, fault_vpn_o and the timeout counter.
- States: IDLE, REQ, WRITE, SETTLE, FAULT.
- IDLE:
  - If tlb_miss_i = 1 and privilege_i = 0: latch miss_vpn_i into vpn_q and go to REQ.
  - Otherwise stay in IDLE.
  - busy_o = 0.
- REQ:
  - mem_req_o = 1.
  - mem_addr_o = ptbr_i + {vpn_q, 2'b00}. The sum is mod 2^32; wrap-around is ignored.
  - ptbr_i is sampled every cycle, so software must hold it stable during a walk.
  - Timeout counter starts at 0 on entry and increments each cycle without an ack.
  - On mem_ack_i with mem_data_i[31] = 1: latch PPN and go to WRITE.
  - On mem_ack_i with mem_data_i[31] = 0: go to FAULT.
  - If the counter reaches TIMEOUT-1 without an ack: go to FAULT.
  - If an ack and the timeout occur in the same cycle, the ack wins.
  - busy_o = 1.
- WRITE:
  - Exactly one cycle with write_enable_o = 1, w_virtual_page_o = vpn_q, w_phys_page_o = latched PPN.
  - mem_req_o = 0, busy_o = 1.
  - Next state is SETTLE.
- SETTLE:
  - One cycle with busy_o = 1 and tlb_miss_i ignored, so the TLB lookup re-evaluates against the new entry.
  - Next state is IDLE.
  - A miss still present in the following IDLE cycle starts a new walk; this covers replacement conflicts.
- FAULT:
  - fault_o = 1, fault_vpn_o = vpn_q, busy_o = 0 (the exception path owns the pipeline).
  - tlb_miss_i is ignored.
  - On fault_clear_i = 1: fault_o drops in the next cycle and the state returns to IDLE.
- write_enable_o is 0 in every state except WRITE. w_virtual_page_o and w_phys_page_o hold their last values outside WRITE.
- A late mem_ack_i arriving outside REQ is ignored.
- Miss-to-TLB-write latency = 2 + N cycles, where N is the number of cycles mem_req_o is held before the ack.
- Reset asserted mid-walk aborts immediately: mem_req_o and write_enable_o drop asynchronously and no partial TLB write occurs.

Test Plan:
- ptbr_i = 0x1000, miss on VPN 2, ack after 3 cycles with mem_data_i = 0x8000_0004 -> mem_addr_o = 0x1008. write_enable_o pulses for one cycle with w_virtual_page_o = 2 and w_phys_page_o = 4. The TLB then translates VPN 2 to 0x4000.
- privilege_i = 1 with tlb_miss_i = 1 -> mem_req_o and busy_o stay 0 for 10 cycles.
- Miss on VPN 45, ack with mem_data_i = 0x0000_0006 -> fault_o = 1, fault_vpn_o = 45, no write_enable_o. After a one-cycle fault_clear_i pulse, fault_o = 0 and the state is IDLE.
- Miss on VPN 3, mem_ack_i never asserted, TIMEOUT = 64 -> fault_o rises exactly 64 cycles after mem_req_o rises.
- Back-to-back misses on VPNs 5, 6, 7, 8 (PPNs 7, 8, 9, 10), each acked in 1 cycle -> four single-cycle writes with the correct pairs, and at least one idle cycle plus SETTLE between walks.
- reset driven low 2 cycles into REQ -> all outputs 0 immediately. After release, no write for the aborted VPN and the controller is in IDLE.
